uart_rx_core: RTL

UART receiver paired with the existing transmitter on the Basys UART link. It samples the serial line `Rx` using the same 16x oversampling `Tick` from the shared baud generator. It deframes start / `NBits` data / stop bits, LSB first, and presents the received byte with a one-cycle `RxDone` strobe. It sits between the board RX pin and the host-side logic, and flags framing errors instead of delivering corrupt bytes.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_sync.sv | 26 ++
 rtl/uart_rx_core.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and frame constants.
// Also used by the transmitter and the baud generator.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_state_e;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_MID_TICK   = 7;
    localparam int UART_MIN_BITS   = 5;
    localparam int UART_MAX_BITS   = 8;

    // Out-of-range data-bit counts snap to the nearest legal width.
    function automatic logic [3:0] uart_clamp_bits(input logic [3:0] n);
        if (n < 4'(UART_MIN_BITS)) begin
            return 4'(UART_MIN_BITS);
        end
        if (n > 4'(UART_MAX_BITS)) begin
            return 4'(UART_MAX_BITS);
        end
        return n;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// N-flop synchronizer for an asynchronous single-bit input.
// Reset value is configurable; UART lines reset to 1 (idle).
module uart_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the async input through the flop chain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: 16x oversampled, start/NBits data/stop, LSB first.
// Bad stop bits raise FrameErr and park in BREAK until the line idles.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = UART_OVERSAMPLE,
    parameter int SYNC_STAGES = 2
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Tick,
    input  logic       Rx,
    input  logic [3:0] NBits,
    output logic [7:0] RxData,
    output logic       RxDone,
    output logic       FrameErr,
    output logic       Busy
);

    localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);

    logic        rx_s;
    uart_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  bcnt_q, bcnt_d;
    logic [7:0]  sh_q, sh_d;
    logic [3:0]  nb_q, nb_d;
    logic [7:0]  rxdata_q, rxdata_d;
    logic        done_q, done_d;
    logic        ferr_q, ferr_d;
    logic        busy_q, busy_d;
    logic [2:0]  last_bit;

    uart_sync #(
        .STAGES (SYNC_STAGES),
        .RST_VAL(1'b1)
    ) u_sync (
        .clk_i (Clk),
        .rst_ni(Rst_n),
        .d_i   (Rx),
        .q_o   (rx_s)
    );

    assign last_bit = 3'(nb_q - 4'd1);

    // Next-state, counters, shift register and output strobes.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bcnt_d   = bcnt_q;
        sh_d     = sh_q;
        nb_d     = nb_q;
        rxdata_d = rxdata_q;
        done_d   = 1'b0;
        ferr_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    cnt_d   = 4'd0;
                    state_d = START;
                end
            end
            START: begin
                if (Tick) begin
                    if (cnt_q == MID_TICK) begin
                        if (!rx_s) begin
                            cnt_d   = 4'd0;
                            bcnt_d  = 3'd0;
                            nb_d    = uart_clamp_bits(NBits);
                            state_d = DATA;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (Tick) begin
                    if (cnt_q == LAST_TICK) begin
                        sh_d   = {rx_s, sh_q[7:1]};
                        bcnt_d = bcnt_q + 3'd1;
                        cnt_d  = 4'd0;
                        if (bcnt_q == last_bit) begin
                            state_d = STOP;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (Tick) begin
                    if (cnt_q == LAST_TICK) begin
                        cnt_d = 4'd0;
                        if (rx_s) begin
                            rxdata_d = sh_q >> (4'd8 - nb_q);
                            done_d   = 1'b1;
                            state_d  = IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = BREAK;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and datapath registers; reset discards any partial frame.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            bcnt_q   <= 3'd0;
            sh_q     <= 8'h00;
            nb_q     <= 4'(UART_MAX_BITS);
            rxdata_q <= 8'h00;
            done_q   <= 1'b0;
            ferr_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bcnt_q   <= bcnt_d;
            sh_q     <= sh_d;
            nb_q     <= nb_d;
            rxdata_q <= rxdata_d;
            done_q   <= done_d;
            ferr_q   <= ferr_d;
            busy_q   <= busy_d;
        end
    end

    assign RxData   = rxdata_q;
    assign RxDone   = done_q;
    assign FrameErr = ferr_q;
    assign Busy     = busy_q;

endmodule
